// File: rtl/mod_exp_engine.sv
// mod_exp_engine: base^exponent mod modulus using bit-serial interleaved modular
// multiplication and left-to-right square-and-multiply.
module mod_exp_engine #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] exponent,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, REDUCE, SCAN, SQUARE, MULT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d, mod_q, mod_d, exp_q, exp_d;
    logic [WIDTH-1:0] r_q, r_d, acc_q, acc_d, res_q, res_d;
    logic [IW-1:0]    bit_q, bit_d, idx_q, idx_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mul_x, mul_y, mm;
    logic [WIDTH:0]   n_ext, t_dbl, t_red, t_add;
    logic             last;

    // base_q holds the raw base during REDUCE and the reduced b afterwards
    assign mul_x = state_q == REDUCE ? WIDTH'(1) : state_q == MULT ? base_q : r_q;
    assign mul_y = state_q == REDUCE ? base_q : r_q;
    assign n_ext = {1'b0, mod_q};
    assign t_dbl = {acc_q, 1'b0};
    assign t_red = t_dbl >= n_ext ? t_dbl - n_ext : t_dbl;
    assign t_add = mul_y[bit_q] ? t_red + {1'b0, mul_x} : t_red;
    assign mm    = WIDTH'(t_add >= n_ext ? t_add - n_ext : t_add);
    assign last  = bit_q == '0;

    assign result = res_q;
    assign err    = err_q;
    assign done   = state_q == DONE;
    assign busy   = state_q == REDUCE || state_q == SCAN || state_q == SQUARE || state_q == MULT;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        mod_d   = mod_q;
        exp_d   = exp_q;
        r_d     = r_q;
        acc_d   = acc_q;
        res_d   = res_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                base_d = base;
                mod_d  = modulus;
                exp_d  = exponent;
                err_d  = modulus < WIDTH'(2);
                acc_d  = '0;
                bit_d  = TOP;
                if (modulus < WIDTH'(2)) begin
                    res_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                acc_d = mm;
                bit_d = bit_q - IW'(1);
                if (last) begin
                    base_d  = mm;
                    idx_d   = TOP;
                    state_d = SCAN;
                end
            end
            SCAN: if (exp_q[idx_q]) begin
                r_d = base_q;
                if (idx_q == '0) begin
                    res_d   = base_q;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    acc_d   = '0;
                    bit_d   = TOP;
                    state_d = SQUARE;
                end
            end else if (idx_q == '0) begin
                r_d     = WIDTH'(1);
                res_d   = WIDTH'(1);
                state_d = DONE;
            end else begin
                idx_d = idx_q - IW'(1);
            end
            SQUARE: begin
                acc_d = mm;
                bit_d = bit_q - IW'(1);
                if (last) begin
                    r_d = mm;
                    if (exp_q[idx_q]) begin
                        acc_d   = '0;
                        bit_d   = TOP;
                        state_d = MULT;
                    end else if (idx_q == '0) begin
                        res_d   = mm;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                        acc_d = '0;
                        bit_d = TOP;
                    end
                end
            end
            MULT: begin
                acc_d = mm;
                bit_d = bit_q - IW'(1);
                if (last) begin
                    r_d = mm;
                    if (idx_q == '0) begin
                        res_d   = mm;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        acc_d   = '0;
                        bit_d   = TOP;
                        state_d = SQUARE;
                    end
                end
            end
            // a held upstream done keeps us here instead of retriggering
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            mod_q   <= '0;
            exp_q   <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            mod_q   <= mod_d;
            exp_q   <= exp_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mod_exp_engine.sv
// tb_mod_exp_engine: vector table plus scoreboard-checked runs on 8, 16 and 64 bit
// instances, with reset-abort and input-change corner cases.
module tb_mod_exp_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] a_i = '0, n_i = '0, e_i = '0;
    logic [2:0]  st = '0;
    logic [7:0]  r8;
    logic [15:0] r16;
    logic [63:0] r64;
    logic [2:0]  dn, bz, er;

    mod_exp_engine #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(st[0]), .base(a_i[7:0]),
        .modulus(n_i[7:0]), .exponent(e_i[7:0]), .result(r8), .done(dn[0]), .busy(bz[0]), .err(er[0]));
    mod_exp_engine #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .start(st[1]), .base(a_i[15:0]),
        .modulus(n_i[15:0]), .exponent(e_i[15:0]), .result(r16), .done(dn[1]), .busy(bz[1]), .err(er[1]));
    mod_exp_engine #(.WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .start(st[2]), .base(a_i),
        .modulus(n_i), .exponent(e_i), .result(r64), .done(dn[2]), .busy(bz[2]), .err(er[2]));

    int nchk = 0, nbad = 0;

    typedef struct {logic [63:0] r; int lat; bit ev;} exp_t;
    exp_t sb[$];

    typedef struct {int s; logic [63:0] a, e, n, r; int lat; bit ev, hold, pert;} tv_t;
    tv_t tv[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic logic [63:0] res(input int s);
        return s == 0 ? {56'd0, r8} : s == 1 ? {48'd0, r16} : r64;
    endfunction

    function automatic logic [63:0] powmod(input logic [63:0] a, input logic [63:0] e, input logic [63:0] n);
        logic [127:0] r, b, nn;
        nn = {64'd0, n};
        r  = 128'd1;
        b  = {64'd0, a} % nn;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[63:0];
    endfunction

    function automatic int latency(input logic [63:0] e, input int w);
        int l = 0, h = 0;
        for (int i = 0; i < w; i++) if (e[i]) begin h++; l = i + 1; end
        return e == 0 ? 2 * w : w + (w - l) + 1 + (l + h - 2) * w;
    endfunction

    task automatic run(input int s, input logic [63:0] a, input logic [63:0] e, input logic [63:0] n,
                       input logic [63:0] r, input int lat, input bit ev, input bit hold, input bit pert);
        int c;
        logic [63:0] held;
        exp_t x;
        @(negedge clk);
        a_i = a; e_i = e; n_i = n; st[s] = 1'b1;
        @(posedge clk);
        sb.push_back('{r, lat, ev});
        #1;
        chk("busy_after_accept", bz[s], !ev);
        if (pert) begin
            a_i = ~a; e_i = e ^ 64'h5; n_i = n + 3; st[s] = 1'b0;
        end
        c = 0;
        while (!dn[s] && c < lat + 20) begin
            @(posedge clk); #1; c++;
        end
        x = sb.pop_front();
        chk("result", res(s), x.r);
        chk("latency", c, x.lat);
        chk("err", er[s], x.ev);
        chk("busy_at_done", bz[s], 0);
        held = res(s);
        if (hold && !pert) repeat (4) begin
            @(posedge clk); #1;
            chk("done_held", dn[s], 1);
            chk("no_restart", bz[s], 0);
        end
        st[s] = 1'b0;
        @(posedge clk); #1;
        chk("done_cleared", dn[s], 0);
        chk("result_held", res(s), held);
    endtask

    initial begin
        tv[0]  = '{2, 64'd2, 64'd12, 64'd299, 64'd209, 381, 1'b0, 1'b1, 1'b0};
        tv[1]  = '{0, 64'd3, 64'd5, 64'd11, 64'd1, 38, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{0, 64'd250, 64'd1, 64'd7, 64'd5, 16, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{0, 64'd5, 64'd0, 64'd13, 64'd1, 16, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{0, 64'd9, 64'd3, 64'd1, 64'd0, 0, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{1, 64'd0, 64'd5, 64'd97, 64'd0, 78, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{1, 64'd7, 64'd1, 64'd2, 64'd1, 32, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{1, 64'd65535, 64'd2, 64'd65535, 64'd0, 47, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{1, 64'd4, 64'd0, 64'd0, 64'd0, 0, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{1, 64'd3, 64'd7, 64'd101, 64'd66, 94, 1'b0, 1'b0, 1'b1};
        tv[10] = '{1, 64'd5, 64'd0, 64'd13, 64'd1, 32, 1'b0, 1'b0, 1'b0};
        tv[11] = '{2, 64'd3, 64'd5, 64'd11, 64'd1, 318, 1'b0, 1'b0, 1'b0};

        @(posedge clk); #1;
        chk("reset_result", r16, 0);
        chk("reset_done", dn, 0);
        chk("reset_busy", bz, 0);
        chk("reset_err", er, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run(tv[i].s, tv[i].a, tv[i].e, tv[i].n, tv[i].r, tv[i].lat, tv[i].ev, tv[i].hold, tv[i].pert);

        for (int i = 0; i < 24; i++) begin
            logic [63:0] a, e, n;
            a = 64'($urandom_range(0, 65535));
            n = i == 0 ? 64'd65535 : 64'($urandom_range(2, 65535));
            e = i == 1 ? 64'hFFFF : i % 4 == 2 ? 64'($urandom_range(0, 3)) : 64'($urandom_range(0, 65535));
            run(1, a, e, n, powmod(a, e, n), latency(e, 16), 1'b0, 1'b0, 1'b0);
        end

        // abort mid-SQUARE: e=FFFF enters SQUARE after edge 17
        @(negedge clk);
        a_i = 64'd3; n_i = 64'd1009; e_i = 64'hFFFF; st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        repeat (25) @(posedge clk);
        #3;
        chk("busy_pre_reset", bz[1], 1);
        rst_n = 1'b0;
        #1;
        chk("abort_result", r16, 0);
        chk("abort_busy", bz[1], 0);
        chk("abort_done", dn[1], 0);
        chk("abort_err", er[1], 0);
        @(negedge clk) rst_n = 1'b1;
        run(1, 64'd3, 64'd5, 64'd1009, 64'd243, 78, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nbad);
        $finish;
    end
endmodule

// File: doc/mod_exp_engine.md
# mod_exp_engine

Downstream stage of the exponent builder: once the exponent product `e` is final, this block computes `result = base^e mod modulus` for the Pollard p-1 step. It uses bit-serial interleaved modular multiplication and left-to-right square-and-multiply. Its level-held `start` is intended to be driven by the upstream `done` flag. `result` feeds the gcd(result-1, n) stage.

## Interface
- `WIDTH`, 64, operand width for base, modulus, exponent and result.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request; sampled only in IDLE.
- `base`  in  WIDTH  base a; any value, reduced internally.
- `modulus`  in  WIDTH  n; must be ≥ 2.
- `exponent`  in  WIDTH  e.
- `result`  out  WIDTH  a^e mod n.
- `done`  out  1  result valid.
- `busy`  out  1  computation in progress.
- `err`  out  1  modulus < 2 on the last accepted request.

## Operation
- **States:** IDLE, REDUCE, SCAN, SQUARE, MULT, DONE.
- **Accept:**
  - Condition: IDLE and `start`=1.
  - Capture `base`, `modulus` and `exponent` into registers. Later input changes are ignored.
  - Clear `done` and `err`.
- **Invalid modulus:** if modulus < 2 at accept, go straight to DONE with result=0 and err=1.
- **Valid modulus:** otherwise go to REDUCE with busy=1.
- **Modmul(x, y) core:**
  - Sequence: acc=0; one multiplier bit y[j] per cycle, j from WIDTH-1 down to 0.
  - Each cycle: t=2·acc; if t≥n then t-=n; if y[j] then t+=x; if t≥n then t-=n.
  - Takes WIDTH cycles. The intermediate is WIDTH+1 bits. Requires x < n.
- **REDUCE:** modmul(1, base) gives b = base mod n.
- **SCAN:** one exponent bit per cycle from index WIDTH-1 downward.
  - Bit is 0: decrement the index.
  - First set bit (MSB): r=b and decrement the index. If that bit was index 0, go to DONE; otherwise go to SQUARE.
  - All bits 0: go to DONE with r=1.
- **SQUARE:** r=modmul(r, r). Then MULT if e[idx]=1, else the next bit.
- **MULT:** r=modmul(b, r).
- **Completion:** after bit 0 has been processed, go to DONE with result=r, done=1, busy=0.
- **DONE:** holds while `start`=1, so a held upstream `done` does not retrigger. On `start`=0, return to IDLE next edge and clear done. result and err hold until the next accept.
- **Other rules:**
  - `start` deassertion mid-computation is ignored.
  - base ≥ n is legal, and base=0 with e>0 gives 0.

## Timing
- **Reset:** asynchronous assert and synchronous release.
  - During reset: state=IDLE, result=0, done=0, busy=0, err=0, and all internal registers 0.
  - Reset mid-operation aborts without producing a result.
- **Latency:** accept edge = edge 0. L = bit-length of e, H = popcount(e).
  - done first high after edge N = WIDTH + (WIDTH−L) + 1 + (L+H−2)·WIDTH.
  - e=0: N = 2·WIDTH.
  - err case: done high after edge 0.
- **busy:** high from after edge 0 through the edge that sets done.
- **Restart:** a new accept requires at least one low cycle of `start` after done, then start high in IDLE.
- **Handshake:** result and done update on the same edge; result is stable whenever done=1.

## Test plan
- WIDTH=64, base=2, modulus=299, exponent=12, start held high → result=209 and done high after edge 381. Verify done stays high while start held, and no restart occurs.
- WIDTH=8, base=3, modulus=11, exponent=5 → result=1 after edge 38. Then base=300-style overflow case: base=250, modulus=7, exponent=1 → result=5 after edge 16.
- Exponent=0, modulus=13 → result=1 after edge 2·WIDTH. Modulus=1 → err=1, result=0, done after edge 0.
- Assert rst_n low mid-SQUARE → outputs 0 immediately. After release, a new start computes correctly.
- Change base/modulus/exponent and drop start during busy → result matches the values captured at accept. Drop start in DONE → IDLE, done=0, result held.
- Random regression at WIDTH=16 against a software pow-mod reference, including all-ones exponent and modulus=2^16−1.
